// File: rtl/serializador_if.sv
// rtl/serializador_if.sv - parallel word in, serial frame out, ack/status/error bundle
interface serializador_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid_in;
  logic             data_ready_out;
  logic             data_out;
  logic             write_out;
  logic             ack_in;
  logic             status_out;
  logic             error_out;

  modport master (
    output data_in, data_valid_in, ack_in,
    input  data_ready_out, data_out, write_out, status_out, error_out
  );

  modport slave (
    input  data_in, data_valid_in, ack_in,
    output data_ready_out, data_out, write_out, status_out, error_out
  );
endinterface

// File: rtl/serializador.sv
// rtl/serializador.sv - MSB-first word serializer with ack timeout, bounded retry and drop
module serializador #(
  parameter int WIDTH       = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic          clk_100KHz,
  input  logic          reset,
  serializador_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_ACK = 2'd2} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] hold_q, shift_q;
  logic [BW-1:0]    bit_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [RW-1:0]    retry_cnt;
  logic             armed_q, error_q;
  logic             ready, accept, last_bit, timeout, retry_ok, drop;

  // armed_q keeps ready low until the first edge after reset releases
  assign ready    = armed_q && (state == IDLE);
  assign accept   = ready && bus.data_valid_in;
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));
  assign timeout  = (tmo_cnt == TW'(ACK_TIMEOUT - 1));
  assign retry_ok = (retry_cnt < RW'(MAX_RETRY));

  assign bus.data_ready_out = ready;
  assign bus.write_out      = (state == SEND);
  assign bus.data_out       = (state == SEND) ? shift_q[WIDTH-1] : 1'b0;
  assign bus.status_out     = (state != IDLE);
  assign bus.error_out      = error_q;

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ack wins over a coincident timeout
  always_comb begin
    state_next = state;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = SEND;
      end
      SEND: begin
        if (last_bit) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.ack_in) begin
          state_next = IDLE;
        end else if (timeout) begin
          if (retry_ok) begin
            state_next = SEND;
          end else begin
            state_next = IDLE;
            drop       = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      armed_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      error_q <= drop;
      case (state)
        IDLE: begin
          if (accept) begin
            hold_q    <= bus.data_in;
            shift_q   <= bus.data_in;
            bit_cnt   <= '0;
            retry_cnt <= '0;
          end
        end
        SEND: begin
          shift_q <= shift_q << 1;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          tmo_cnt <= '0;
        end
        WAIT_ACK: begin
          if (!bus.ack_in && timeout && retry_ok) begin
            retry_cnt <= retry_cnt + 1'b1;
            shift_q   <= hold_q;
            tmo_cnt   <= '0;
          end else if (!timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serializador.sv
// tb/tb_serializador.sv - directed self-checking bench for serializador
module tb_serializador;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  serializador_if #(.WIDTH(WIDTH)) bus ();

  serializador #(.WIDTH(WIDTH), .ACK_TIMEOUT(16), .MAX_RETRY(2)) dut (
    .clk_100KHz(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // serial monitor: captured bits, frame starts, error pulses
  logic [63:0] cap = '0;
  int          nbits = 0;
  int          nframes = 0;
  int          nerr = 0;
  logic        mon_prev_w = 1'b0;

  always @(negedge clk) begin
    if (bus.write_out) begin
      cap   <= {cap[62:0], bus.data_out};
      nbits <= nbits + 1;
      if (!mon_prev_w) nframes <= nframes + 1;
    end
    if (bus.error_out) nerr <= nerr + 1;
    mon_prev_w <= bus.write_out;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] w);
    bus.data_in       = w;
    bus.data_valid_in = 1'b1;
    tick();
    bus.data_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    bus.data_in       = '0;
    bus.data_valid_in = 1'b0;
    bus.ack_in        = 1'b0;
    reset             = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.data_ready_out, bus.write_out, bus.data_out, bus.status_out, bus.error_out} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {bus.data_ready_out, bus.write_out, bus.data_out, bus.status_out, bus.error_out});
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.data_ready_out !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_first_edge got=%b exp=0", bus.data_ready_out);
    end
    tick();
    total++;
    if ({bus.data_ready_out, bus.status_out} !== 2'b10) begin
      bad++;
      $display("FAIL ready_after_release got=%b exp=10", {bus.data_ready_out, bus.status_out});
    end
  endtask

  task automatic test_single_ack();
    logic [7:0] w;
    int e0;
    w  = 8'hA5;
    e0 = nerr;
    put(w);
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({bus.write_out, bus.data_out, bus.data_ready_out, bus.status_out} !== {1'b1, w[7-i], 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL a5_bit%0d got=%b exp=%b", i,
                 {bus.write_out, bus.data_out, bus.data_ready_out, bus.status_out}, {1'b1, w[7-i], 2'b01});
      end
      tick();
    end
    total++;
    if ({bus.write_out, bus.data_out} !== 2'b00) begin
      bad++;
      $display("FAIL a5_after_lsb got=%b exp=00", {bus.write_out, bus.data_out});
    end
    tick();
    tick();
    bus.ack_in = 1'b1;
    tick();
    bus.ack_in = 1'b0;
    total++;
    if ({bus.status_out, bus.data_ready_out} !== 2'b01) begin
      bad++;
      $display("FAIL a5_after_ack got=%b exp=01", {bus.status_out, bus.data_ready_out});
    end
    total++;
    if (nerr !== e0) begin
      bad++;
      $display("FAIL a5_no_error got=%0d exp=%0d", nerr, e0);
    end
  endtask

  task automatic test_timeout_drop();
    logic [7:0] w;
    logic       ew, eb;
    int         pos, e0, f0;
    w  = 8'h3C;
    e0 = nerr;
    f0 = nframes;
    put(w);
    for (int c = 1; c <= 72; c++) begin
      pos = (c - 1) % 24;
      ew  = (pos < 8);
      eb  = ew ? w[7-pos] : 1'b0;
      total++;
      if ({bus.write_out, bus.data_out, bus.error_out} !== {ew, eb, 1'b0}) begin
        bad++;
        $display("FAIL drop_cycle%0d got=%b exp=%b", c,
                 {bus.write_out, bus.data_out, bus.error_out}, {ew, eb, 1'b0});
      end
      tick();
    end
    total++;
    if ({bus.error_out, bus.data_ready_out, bus.status_out} !== 3'b110) begin
      bad++;
      $display("FAIL drop_error_pulse got=%b exp=110",
               {bus.error_out, bus.data_ready_out, bus.status_out});
    end
    tick();
    total++;
    if (bus.error_out !== 1'b0) begin
      bad++;
      $display("FAIL drop_pulse_width got=%b exp=0", bus.error_out);
    end
    total++;
    if ((nerr - e0) !== 1 || (nframes - f0) !== 3) begin
      bad++;
      $display("FAIL drop_counts got=err%0d/frames%0d exp=err1/frames3", nerr - e0, nframes - f0);
    end
  endtask

  task automatic test_retry_ack();
    int e0, f0, b0;
    e0 = nerr;
    f0 = nframes;
    b0 = nbits;
    put(8'hFF);
    repeat (32) tick();
    bus.ack_in = 1'b1;
    tick();
    bus.ack_in = 1'b0;
    total++;
    if (bus.status_out !== 1'b0) begin
      bad++;
      $display("FAIL retry_ack_idle got=%b exp=0", bus.status_out);
    end
    repeat (20) tick();
    total++;
    if ((nframes - f0) !== 2 || (nbits - b0) !== 16 || cap[15:0] !== 16'hFFFF) begin
      bad++;
      $display("FAIL retry_ack_frames got=frames%0d/bits%0d/cap%h exp=frames2/bits16/capffff",
               nframes - f0, nbits - b0, cap[15:0]);
    end
    total++;
    if (nerr !== e0) begin
      bad++;
      $display("FAIL retry_ack_no_error got=%0d exp=%0d", nerr, e0);
    end
  endtask

  task automatic test_ack_at_timeout();
    int e0, f0;
    e0 = nerr;
    f0 = nframes;
    put(8'h5A);
    repeat (71) tick();
    bus.ack_in = 1'b1;
    tick();
    bus.ack_in = 1'b0;
    total++;
    if ({bus.status_out, bus.error_out, bus.data_ready_out} !== 3'b001) begin
      bad++;
      $display("FAIL ack_timeout_idle got=%b exp=001",
               {bus.status_out, bus.error_out, bus.data_ready_out});
    end
    repeat (20) tick();
    total++;
    if ((nframes - f0) !== 3 || (nerr - e0) !== 0 || cap[7:0] !== 8'h5A) begin
      bad++;
      $display("FAIL ack_timeout_counts got=frames%0d/err%0d/cap%h exp=frames3/err0/cap5a",
               nframes - f0, nerr - e0, cap[7:0]);
    end
  endtask

  task automatic test_reset_midframe();
    int e0, f0, b0;
    e0 = nerr;
    put(8'h81);
    repeat (3) tick();
    total++;
    if (bus.write_out !== 1'b1) begin
      bad++;
      $display("FAIL midframe_sending got=%b exp=1", bus.write_out);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.write_out, bus.data_out, bus.status_out, bus.data_ready_out, bus.error_out} !== 5'b00000) begin
      bad++;
      $display("FAIL midframe_abort got=%b exp=00000",
               {bus.write_out, bus.data_out, bus.status_out, bus.data_ready_out, bus.error_out});
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({bus.data_ready_out, bus.status_out} !== 2'b10 || nerr !== e0) begin
      bad++;
      $display("FAIL midframe_recover got=%b/err%0d exp=10/err%0d",
               {bus.data_ready_out, bus.status_out}, nerr, e0);
    end
    f0 = nframes;
    b0 = nbits;
    put(8'h0F);
    repeat (8) tick();
    bus.ack_in = 1'b1;
    tick();
    bus.ack_in = 1'b0;
    total++;
    if (cap[7:0] !== 8'h0F || (nbits - b0) !== 8 || (nframes - f0) !== 1 || bus.status_out !== 1'b0) begin
      bad++;
      $display("FAIL midframe_next_word got=cap%h/bits%0d/frames%0d/st%b exp=cap0f/bits8/frames1/st0",
               cap[7:0], nbits - b0, nframes - f0, bus.status_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    logic [7:0] got [4];
    int   idx, k, f0;
    logic prev_st, prev_wr;
    words[0] = 8'h11;
    words[1] = 8'hC3;
    words[2] = 8'h7E;
    words[3] = 8'h80;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    f0      = nframes;
    idx     = 0;
    k       = 0;
    prev_st = 1'b0;
    prev_wr = 1'b0;
    bus.data_in       = words[0];
    bus.data_valid_in = 1'b1;
    for (int cyc = 0; cyc < 400 && k < 4; cyc++) begin
      tick();
      if (bus.status_out && !prev_st) begin
        idx++;
        if (idx < 4) bus.data_in = words[idx];
        else bus.data_valid_in = 1'b0;
      end
      if (bus.status_out && !bus.write_out && prev_wr) begin
        got[k] = cap[7:0];
        k++;
      end
      bus.ack_in = bus.status_out && !bus.write_out;
      prev_st    = bus.status_out;
      prev_wr    = bus.write_out;
    end
    tick();
    bus.ack_in        = 1'b0;
    bus.data_valid_in = 1'b0;
    total++;
    if (k !== 4) begin
      bad++;
      $display("FAIL b2b_frame_budget got=%0d exp=4", k);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== words[i]) begin
        bad++;
        $display("FAIL b2b_word%0d got=%h exp=%h", i, got[i], words[i]);
      end
    end
    repeat (12) tick();
    total++;
    if ((nframes - f0) !== 4 || bus.status_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_frame_count got=%0d/st%b exp=4/st0", nframes - f0, bus.status_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_ack();
    test_timeout_drop();
    test_retry_ack();
    test_ack_at_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/serializador.md
SERIALIZADOR -- requirements
Module: serializador

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits, legal range 2..16.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: clock cycles spent in WAIT_ACK before a timeout.
REQ-003 SHALL have parameter MAX_RETRY, default 2: retransmissions allowed after a timeout before the word is dropped.
REQ-004 SHALL have port clk_100KHz  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  WIDTH  parallel word to transmit.
REQ-007 SHALL have port data_valid_in  input  1  data_in holds a valid word.
REQ-008 SHALL have port data_ready_out  output  1  block can accept a word this cycle.
REQ-009 SHALL have port data_out  output  1  serial bit, MSB first.
REQ-010 SHALL have port write_out  output  1  data_out carries a valid frame bit this cycle.
REQ-011 SHALL have port ack_in  input  1  receiver acknowledges a complete frame.
REQ-012 SHALL have port status_out  output  1  high while a word is held (any state other than IDLE).
REQ-013 SHALL have port error_out  output  1  one-cycle pulse when a word is dropped after exhausting retries.

Function
REQ-014 SHALL implement states IDLE, SEND, WAIT_ACK; no other reachable states.
REQ-015 IDLE: data_ready_out=1; on data_valid_in=1, SHALL latch data_in into both a hold register and a shift register, clear retry count, and enter SEND at the same edge.
REQ-016 In SEND, WAIT_ACK, data_ready_out SHALL be 0 and data_valid_in/data_in SHALL be ignored.
REQ-017 SEND: write_out=1, data_out=shift[WIDTH-1]; shift left by 1 each cycle; SHALL remain in SEND for exactly WIDTH cycles, then enter WAIT_ACK.
REQ-018 Latency: a word accepted at edge N SHALL drive its MSB during cycle N+1 and its LSB during cycle N+WIDTH; write_out SHALL be low from cycle N+WIDTH+1.
REQ-019 Outside SEND, write_out SHALL be 0 and data_out SHALL be 0.
REQ-020 WAIT_ACK: a timeout counter SHALL start at 0 on entry and increment each cycle; ack_in=1 SHALL return to IDLE at the next edge.
REQ-021 If ack_in is still 0 when the counter reaches ACK_TIMEOUT-1 and retry count < MAX_RETRY, SHALL increment retry count, reload the shift register from the hold register, and re-enter SEND.
REQ-022 If the timeout occurs with retry count = MAX_RETRY, SHALL pulse error_out for exactly one cycle (the first IDLE cycle) and return to IDLE, discarding the word.
REQ-023 ack_in=1 on the same cycle as the timeout SHALL take priority: the frame is treated as acknowledged, with no retry and no error.
REQ-024 ack_in outside WAIT_ACK SHALL be ignored and SHALL NOT affect any state.
REQ-025 Counters SHALL be sized for their maximum values (bit count to WIDTH, timeout to ACK_TIMEOUT, retry to MAX_RETRY) and SHALL NOT wrap within a frame.
REQ-026 Back-to-back operation: once IDLE is re-entered, a new word SHALL be accepted at the first IDLE edge with data_valid_in=1.

Reset
REQ-027 While reset=1, the block SHALL immediately force IDLE, data_ready_out=0, data_out=0, write_out=0, status_out=0, error_out=0, and clear all counters, the shift register and the hold register.
REQ-028 After reset deasserts, data_ready_out SHALL rise at the first clock edge; a reset asserted mid-frame SHALL abort the frame with no error pulse.

Verification
REQ-029 Accept 8'hA5 with ack_in pulsed 3 cycles after LSB -> data_out 1,0,1,0,0,1,0,1 with write_out high for 8 cycles, status_out low after ack, error_out never high.
REQ-030 Accept 8'h3C, ack_in held 0 -> frame sent 3 times (initial + 2 retries), each separated by 16 WAIT_ACK cycles, then single error_out pulse and data_ready_out=1.
REQ-031 Ack on first retry for 8'hFF -> exactly two frames of eight 1s, no error_out.
REQ-032 ack_in coincident with the final timeout cycle -> return to IDLE, no retransmission, error_out=0.
REQ-033 Reset asserted at bit 4 of 8'h81 -> write_out, data_out, status_out drop immediately; after release, 8'h0F is accepted and sent correctly.
REQ-034 data_valid_in held high continuously with prompt acks -> consecutive words accepted one per frame, none duplicated or lost.
